run_sched: RTL



---
 rtl/run_sched.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/run_sched.sv
// rtl/run_sched.sv - round-robin scheduler driving an engine's run/cont/halt inputs
//
// Shares one execution engine among N requesters. The selected requester is
// granted (one-hot gnt), the engine is started with a one-cycle run pulse, and
// the slice is either extended (cont) when nobody else waits or preempted
// (halt) when the quantum expires with other requests pending.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   req      - level request per requester
//   done     - engine job complete for the current grant (sampled in ACTIVE)
//   gnt      - one-hot grant
//   run      - one-cycle engine start pulse
//   cont     - one-cycle slice-extension pulse
//   halt     - one-cycle engine stop pulse
//   busy     - scheduler not idle
//   done_vld - one-cycle pulse, grant ended through done
//   done_id  - index of the completed requester, valid with done_vld
//   cs       - current state code
module run_sched #(
    parameter int N       = 4,
    parameter int QUANTUM = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         run,
    output logic         cont,
    output logic         halt,
    output logic         busy,
    output logic         done_vld,
    output logic [2:0]   done_id,
    output logic [2:0]   cs
);

    localparam int             CW     = $clog2(QUANTUM);
    localparam logic [CW-1:0]  RELOAD = CW'(QUANTUM - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_START   = 3'b001,
        S_ACTIVE  = 3'b010,
        S_STOP    = 3'b011,
        S_RELEASE = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    last_q, last_d;
    logic [2:0]    idx_q, idx_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          run_q, run_d;
    logic          cont_q, cont_d;
    logic          halt_q, halt_d;
    logic          busy_q, busy_d;
    logic          done_vld_q, done_vld_d;
    logic [2:0]    done_id_q, done_id_d;

    // Round-robin pick: rotate req so that bit 0 is requester last+1, take the
    // lowest set bit, then map the offset back to an absolute index.
    logic [3:0]   shamt;
    logic [N-1:0] rot;
    logic [2:0]   off;
    logic [3:0]   tmp;
    logic [2:0]   pick;
    logic [N-1:0] pick_oh;

    always_comb begin
        shamt = {1'b0, last_q} + 4'd1;
        rot   = N'({req, req} >> shamt);
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        tmp = {1'b0, last_q} + 4'd1 + {1'b0, off};
        if (tmp >= 4'(N)) tmp = tmp - 4'(N);
        pick    = tmp[2:0];
        pick_oh = {{(N-1){1'b0}}, 1'b1} << pick;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        idx_d      = idx_q;
        gnt_d      = gnt_q;
        run_d      = 1'b0;
        cont_d     = 1'b0;
        halt_d     = 1'b0;
        done_vld_d = 1'b0;
        done_id_d  = done_id_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = pick_oh;
                    idx_d   = pick;
                    run_d   = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = RELOAD;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (done) begin
                    gnt_d      = '0;
                    done_vld_d = 1'b1;
                    done_id_d  = idx_q;
                    state_d    = S_RELEASE;
                end else if (!cont_q && !(|(req & gnt_q))) begin
                    // A withdrawal seen while cont is on the wire is acted on one
                    // cycle later so cont and halt never land back to back.
                    halt_d  = 1'b1;
                    state_d = S_STOP;
                end else if (cnt_q == '0 && |(req & ~gnt_q)) begin
                    halt_d  = 1'b1;
                    state_d = S_STOP;
                end else if (cnt_q == '0) begin
                    cnt_d  = RELOAD;
                    cont_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                gnt_d   = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 3'(N - 1);
            idx_q      <= '0;
            gnt_q      <= '0;
            run_q      <= 1'b0;
            cont_q     <= 1'b0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_vld_q <= 1'b0;
            done_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            gnt_q      <= gnt_d;
            run_q      <= run_d;
            cont_q     <= cont_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            done_vld_q <= done_vld_d;
            done_id_q  <= done_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign run      = run_q;
    assign cont     = cont_q;
    assign halt     = halt_q;
    assign busy     = busy_q;
    assign done_vld = done_vld_q;
    assign done_id  = done_id_q;
    assign cs       = state_q;

endmodule
